// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: pixel-pull test-pattern source for the HDMI encoder.
// Ports: i_pixclk/i_reset_n clock and async active-low reset; i_width/i_height
// runtime frame size; i_mode pattern request (taken at i_newframe); i_rd/
// i_newline/i_newframe encoder pull handshake; o_pixel registered {r,g,b};
// o_mode mode of the current frame; o_frame_cnt frames started since reset.
// Modes: 0 colour bars, 1 checkerboard, 2 gradient, 3 bouncing box.
// Define HDMI_PATTERN_BORDER_EN to add a red one-pixel frame border.
module hdmi_pattern_gen #(
  parameter int BITS_PER_COLOR = 8,
  parameter int HW = 16,
  parameter int CHECKER_LOG2 = 3,
  parameter int BOX_SIZE = 32
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset_n,
  input  logic [HW-1:0]               i_width,
  input  logic [HW-1:0]               i_height,
  input  logic [1:0]                  i_mode,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [1:0]                  o_mode,
  output logic [15:0]                 o_frame_cnt
);
  localparam int B = BITS_PER_COLOR;
  localparam int PW = 3 * B;
  logic [HW-1:0] x, y, nx, ny, bx, by, nbx, nby, bar_cnt, nbar_cnt, bar_w, nbar_w;
  logic          dx, dy, ndx, ndy, bar_last;
  logic [2:0]    bar_idx, nbar_idx;
  logic [1:0]    nmode;
  logic [15:0]   nfc;
  logic [PW-1:0] pat, pix, npix;
  logic          in_box;
  // One bounce step on one axis; returns {direction, position}. A blocked
  // step reverses direction and moves the other way if that is possible.
  function automatic logic [HW:0] box_step(input logic [HW-1:0] p, input logic d,
                                           input logic [HW-1:0] lim);
    logic inc_ok, dec_ok;
    inc_ok = ({2'b0, p} + (HW+2)'(BOX_SIZE) + (HW+2)'(1)) <= {2'b0, lim};
    dec_ok = p != {HW{1'b0}};
    if ({2'b0, lim} < (HW+2)'(BOX_SIZE)) return {d, {HW{1'b0}}};
    if (d) return inc_ok ? {1'b1, p + 1'b1} : {1'b0, dec_ok ? p - 1'b1 : p};
    return dec_ok ? {1'b0, p - 1'b1} : {1'b1, inc_ok ? p + 1'b1 : p};
  endfunction
  always_comb begin
    nx = x;
    ny = y;
    nmode = o_mode;
    nfc = o_frame_cnt;
    nbar_w = bar_w;
    nbar_cnt = bar_cnt;
    nbar_idx = bar_idx;
    {ndx, nbx} = {dx, bx};
    {ndy, nby} = {dy, by};
    bar_last = bar_cnt == bar_w - 1'b1;
    if (i_newframe) begin
      nx = '0;
      ny = '0;
      nmode = i_mode;
      nfc = o_frame_cnt + 16'd1;
      nbar_w = i_width >> 3;
      nbar_cnt = '0;
      nbar_idx = '0;
      {ndx, nbx} = box_step(bx, dx, i_width);
      {ndy, nby} = box_step(by, dy, i_height);
    end else if (i_newline) begin
      nx = '0;
      ny = (y >= i_height) ? i_height : y + 1'b1;
      nbar_cnt = '0;
      nbar_idx = '0;
    end else if (i_rd) begin
      nx = (x >= i_width) ? i_width : x + 1'b1;
      nbar_cnt = bar_last ? '0 : bar_cnt + 1'b1;
      nbar_idx = (bar_last && bar_idx != 3'd7) ? bar_idx + 3'd1 : bar_idx;
    end
  end
  // Patterns are evaluated at the post-update counters so o_pixel always
  // matches the position the encoder will read next.
  always_comb begin
    in_box = nx >= nbx && {1'b0, nx} < {1'b0, nbx} + (HW+1)'(BOX_SIZE) &&
             ny >= nby && {1'b0, ny} < {1'b0, nby} + (HW+1)'(BOX_SIZE);
    pat = (nmode == 2'd0) ? {{B{~nbar_idx[1]}}, {B{~nbar_idx[2]}}, {B{~nbar_idx[0]}}} :
          (nmode == 2'd1) ? {PW{nx[CHECKER_LOG2] ^ ny[CHECKER_LOG2]}} :
          (nmode == 2'd2) ? {nx[B-1:0], ny[B-1:0], nx[B-1:0] ^ ny[B-1:0]} :
          in_box ? {PW{1'b1}} : {{(2*B){1'b0}}, {B{1'b1}}};
`ifdef HDMI_PATTERN_BORDER_EN
    pix = (nx == '0 || ny == '0 || nx == i_width - 1'b1 || ny == i_height - 1'b1) ?
          {{B{1'b1}}, {(2*B){1'b0}}} : pat;
`else
    pix = pat;
`endif
    npix = (nx >= i_width || ny >= i_height) ? '0 : pix;
  end
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x <= '0;
      y <= '0;
      o_pixel <= '0;
      o_mode <= '0;
      o_frame_cnt <= '0;
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
      bar_idx <= '0;
      bar_cnt <= '0;
      bar_w <= '0;
    end else begin
      x <= nx;
      y <= ny;
      o_pixel <= npix;
      o_mode <= nmode;
      o_frame_cnt <= nfc;
      bx <= nbx;
      by <= nby;
      dx <= ndx;
      dy <= ndy;
      bar_idx <= nbar_idx;
      bar_cnt <= nbar_cnt;
      bar_w <= nbar_w;
    end
  end
endmodule
